// File: rtl/trigger_ctrl.sv
// Trigger controller: qualifies masked channel/protocol triggers (AND/OR), fires on the
// Nth rising edge of the qualified condition, then counts post-trigger samples to done.
module trigger_ctrl #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned OCC_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              armed,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              prot_trig,
  input  logic              prot_en,
  input  logic              trig_mode,
  input  logic [OCC_W-1:0]  occ_target,
  input  logic [CNT_W-1:0]  post_cnt,
  input  logic              smpl_en,
  output logic              triggered,
  output logic              capture_done,
  output logic [OCC_W-1:0]  occ_cnt,
  output logic [CNT_W-1:0]  post_smpl_cnt,
  output logic [1:0]        trig_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRIG  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;

  logic [NUM_CH-1:0] mask_q;
  logic              pen_q;
  logic              mode_q;
  logic [OCC_W-1:0]  occ_tgt_q;
  logic [CNT_W-1:0]  post_q;

  logic              cond_q;
  logic              cond;
  logic              evt;

  logic [NUM_CH-1:0] mask_e;
  logic              pen_e;
  logic              mode_e;

  logic [OCC_W-1:0]  eff_tgt;
  logic [OCC_W:0]    occ_inc;
  logic [CNT_W-1:0]  smpl_inc;

  // In IDLE the live config is evaluated, so cond_q captured on the arming edge already
  // reflects the config being latched; a condition true at arming then yields no event.
  always_comb begin
    if (state == IDLE) begin
      mask_e = ch_mask;
      pen_e  = prot_en;
      mode_e = trig_mode;
    end else begin
      mask_e = mask_q;
      pen_e  = pen_q;
      mode_e = mode_q;
    end

    if ((mask_e == '0) && !pen_e) begin
      cond = 1'b0;
    end else if (mode_e) begin
      cond = (|(ch_trig & mask_e)) | (prot_trig & pen_e);
    end else begin
      cond = (&(ch_trig | ~mask_e)) & (prot_trig | ~pen_e);
    end
  end

  assign evt      = cond & ~cond_q;
  assign eff_tgt  = (occ_tgt_q == '0) ? OCC_W'(1) : occ_tgt_q;
  assign occ_inc  = {1'b0, occ_cnt} + (OCC_W + 1)'(1);
  assign smpl_inc = post_smpl_cnt + CNT_W'(1);

  assign trig_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      triggered     <= 1'b0;
      capture_done  <= 1'b0;
      occ_cnt       <= '0;
      post_smpl_cnt <= '0;
      cond_q        <= 1'b0;
      mask_q        <= '0;
      pen_q         <= 1'b0;
      mode_q        <= 1'b0;
      occ_tgt_q     <= '0;
      post_q        <= '0;
    end else begin
      cond_q <= cond;

      unique case (state)
        IDLE: begin
          triggered     <= 1'b0;
          capture_done  <= 1'b0;
          occ_cnt       <= '0;
          post_smpl_cnt <= '0;
          if (armed) begin
            state     <= ARMED;
            mask_q    <= ch_mask;
            pen_q     <= prot_en;
            mode_q    <= trig_mode;
            occ_tgt_q <= occ_target;
            post_q    <= post_cnt;
          end
        end

        ARMED: begin
          if (!armed) begin
            state   <= IDLE;
            occ_cnt <= '0;
          end else if (evt) begin
            occ_cnt <= occ_inc[OCC_W-1:0];
            if (occ_inc >= {1'b0, eff_tgt}) begin
              state     <= TRIG;
              triggered <= 1'b1;
            end
          end
        end

        TRIG: begin
          if (!armed) begin
            state         <= IDLE;
            triggered     <= 1'b0;
            occ_cnt       <= '0;
            post_smpl_cnt <= '0;
          end else if (post_q == '0) begin
            state        <= DONE;
            triggered    <= 1'b0;
            capture_done <= 1'b1;
          end else if (smpl_en) begin
            post_smpl_cnt <= smpl_inc;
            if (smpl_inc == post_q) begin
              state        <= DONE;
              triggered    <= 1'b0;
              capture_done <= 1'b1;
            end
          end
        end

        DONE: begin
          if (!armed) begin
            state         <= IDLE;
            capture_done  <= 1'b0;
            occ_cnt       <= '0;
            post_smpl_cnt <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed bench for trigger_ctrl: per-cycle expectations queued at drive time and
// checked one edge later against the registered outputs.
module tb_trigger_ctrl;

  localparam int unsigned NUM_CH = 5;
  localparam int unsigned OCC_W  = 8;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              armed;
  logic [NUM_CH-1:0] ch_trig;
  logic [NUM_CH-1:0] ch_mask;
  logic              prot_trig;
  logic              prot_en;
  logic              trig_mode;
  logic [OCC_W-1:0]  occ_target;
  logic [CNT_W-1:0]  post_cnt;
  logic              smpl_en;
  logic              triggered;
  logic              capture_done;
  logic [OCC_W-1:0]  occ_cnt;
  logic [CNT_W-1:0]  post_smpl_cnt;
  logic [1:0]        trig_state;

  trigger_ctrl #(
    .NUM_CH (NUM_CH),
    .OCC_W  (OCC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .armed         (armed),
    .ch_trig       (ch_trig),
    .ch_mask       (ch_mask),
    .prot_trig     (prot_trig),
    .prot_en       (prot_en),
    .trig_mode     (trig_mode),
    .occ_target    (occ_target),
    .post_cnt      (post_cnt),
    .smpl_en       (smpl_en),
    .triggered     (triggered),
    .capture_done  (capture_done),
    .occ_cnt       (occ_cnt),
    .post_smpl_cnt (post_smpl_cnt),
    .trig_state    (trig_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic        trg;
    logic        dn;
    logic [7:0]  occ;
    logic [15:0] ps;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] st, input logic trg,
                      input logic dn, input logic [7:0] occ, input logic [15:0] ps);
    exp_t e;
    e.tag = tag; e.st = st; e.trg = trg; e.dn = dn; e.occ = occ; e.ps = ps;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".state"}, 32'(trig_state), 32'(e.st));
      chk({e.tag, ".trg"},   32'(triggered), 32'(e.trg));
      chk({e.tag, ".done"},  32'(capture_done), 32'(e.dn));
      chk({e.tag, ".occ"},   32'(occ_cnt), 32'(e.occ));
      chk({e.tag, ".post"},  32'(post_smpl_cnt), 32'(e.ps));
    end
  endtask

  // Queue expectation for the edge ending the current cycle, then sample #1 after it.
  task automatic cyc(input string tag, input logic [1:0] st, input logic trg,
                     input logic dn, input logic [7:0] occ, input logic [15:0] ps);
    push(tag, st, trg, dn, occ, ps);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  initial begin
    rst_n = 1'b0; armed = 1'b0; ch_trig = '0; ch_mask = '0; prot_trig = 1'b0;
    prot_en = 1'b0; trig_mode = 1'b0; occ_target = '0; post_cnt = '0; smpl_en = 1'b0;
    cyc("reset", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);
    rst_n = 1'b1;
    cyc("idle", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    // AND mode, all sources, occ 1, post 3
    ch_mask = 5'b11111; prot_en = 1'b1; trig_mode = 1'b0; occ_target = 8'd1; post_cnt = 16'd3;
    armed = 1'b1;
    cyc("and_arm", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b11011; prot_trig = 1'b1;
    cyc("and_partial", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b11111; smpl_en = 1'b1;
    cyc("and_fire", 2'd2, 1'b1, 1'b0, 8'd1, 16'd0);
    smpl_en = 1'b0;
    cyc("and_trig_wait", 2'd2, 1'b1, 1'b0, 8'd1, 16'd0);
    smpl_en = 1'b1;
    cyc("and_s1", 2'd2, 1'b1, 1'b0, 8'd1, 16'd1);
    cyc("and_s2", 2'd2, 1'b1, 1'b0, 8'd1, 16'd2);
    cyc("and_s3_done", 2'd3, 1'b0, 1'b1, 8'd1, 16'd3);
    cyc("and_done_hold", 2'd3, 1'b0, 1'b1, 8'd1, 16'd3);
    smpl_en = 1'b0; armed = 1'b0; ch_trig = '0; prot_trig = 1'b0;
    cyc("and_disarm", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    // OR mode, only channel 2; then abort after 1 of 4 samples
    ch_mask = 5'b00100; prot_en = 1'b0; trig_mode = 1'b1; occ_target = 8'd1; post_cnt = 16'd4;
    armed = 1'b1;
    cyc("or_arm", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b00001; prot_trig = 1'b1;
    cyc("or_ch0", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = '0;
    cyc("or_ch0_low", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b00100;
    cyc("or_ch2_fire", 2'd2, 1'b1, 1'b0, 8'd1, 16'd0);
    ch_trig = '0; prot_trig = 1'b0; smpl_en = 1'b1;
    cyc("abort_s1", 2'd2, 1'b1, 1'b0, 8'd1, 16'd1);
    armed = 1'b0;
    cyc("abort_idle", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);
    smpl_en = 1'b0;
    cyc("abort_stay", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    // occ_target 3, post 0
    ch_mask = 5'b00001; occ_target = 8'd3; post_cnt = 16'd0; armed = 1'b1;
    cyc("occ_arm", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b00001;
    cyc("occ_e1", 2'd1, 1'b0, 1'b0, 8'd1, 16'd0);
    ch_trig = '0;
    cyc("occ_l1", 2'd1, 1'b0, 1'b0, 8'd1, 16'd0);
    ch_trig = 5'b00001;
    cyc("occ_e2", 2'd1, 1'b0, 1'b0, 8'd2, 16'd0);
    ch_trig = '0;
    cyc("occ_l2", 2'd1, 1'b0, 1'b0, 8'd2, 16'd0);
    ch_trig = 5'b00001;
    cyc("occ_e3", 2'd2, 1'b1, 1'b0, 8'd3, 16'd0);
    cyc("occ_post0", 2'd3, 1'b0, 1'b1, 8'd3, 16'd0);
    armed = 1'b0;
    cyc("occ_disarm", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    // condition held high across arming
    cyc("held_idle", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);
    armed = 1'b1;
    cyc("held_arm", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    cyc("held_hold", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = '0;
    cyc("held_fall", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b00001;
    cyc("held_rerise", 2'd1, 1'b0, 1'b0, 8'd1, 16'd0);
    armed = 1'b0; ch_trig = '0;
    cyc("held_abort", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    // nothing enabled, AND mode
    ch_mask = '0; prot_en = 1'b0; trig_mode = 1'b0; occ_target = 8'd1; armed = 1'b1;
    cyc("none_arm", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b11111; prot_trig = 1'b1;
    cyc("none_high", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = '0; prot_trig = 1'b0;
    cyc("none_low", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b11111; prot_trig = 1'b1;
    cyc("none_high2", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    armed = 1'b0; ch_trig = '0; prot_trig = 1'b0;
    cyc("none_disarm", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    // mask change mid-ARMED ignored; occ_target 0 acts as 1
    ch_mask = 5'b00010; trig_mode = 1'b1; occ_target = 8'd0; post_cnt = 16'd1; armed = 1'b1;
    cyc("latch_arm", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_mask = 5'b00001; ch_trig = 5'b00001;
    cyc("latch_ignored", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = '0;
    cyc("latch_low", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b00010;
    cyc("latch_fire", 2'd2, 1'b1, 1'b0, 8'd1, 16'd0);
    smpl_en = 1'b1;
    cyc("latch_done", 2'd3, 1'b0, 1'b1, 8'd1, 16'd1);
    smpl_en = 1'b0; armed = 1'b0; ch_trig = '0;
    cyc("latch_disarm", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    // event coinciding with armed fall
    ch_mask = 5'b00001; occ_target = 8'd1; post_cnt = 16'd2; armed = 1'b1;
    cyc("coin_arm", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b00001; armed = 1'b0;
    cyc("coin_abort", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = '0;
    cyc("coin_idle", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    // asynchronous reset during TRIG
    post_cnt = 16'd5; armed = 1'b1;
    cyc("ar_arm", 2'd1, 1'b0, 1'b0, 8'd0, 16'd0);
    ch_trig = 5'b00001;
    cyc("ar_fire", 2'd2, 1'b1, 1'b0, 8'd1, 16'd0);
    smpl_en = 1'b1;
    cyc("ar_s1", 2'd2, 1'b1, 1'b0, 8'd1, 16'd1);
    #1;
    push("ar_async", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);
    rst_n = 1'b0;
    #1;
    pop_cmp();
    armed = 1'b0; smpl_en = 1'b0; ch_trig = '0;
    #2;
    rst_n = 1'b1;
    cyc("ar_after", 2'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
